w5300_bus_ctrl: RTL
===================

Name: w5300_bus_ctrl

Overview:
Host-side parallel bus master for the Wiznet W5300 in direct-address, 16-bit data-bus mode.
- Drives the chip hardware reset and power-up wait.
- Turns single register-access requests (10-bit address from the W5300 package register map, RD/WR operation) into timed CS/RD/WR strobe cycles.
- Returns read data and completion status.
- Sits between the socket/configuration sequencers upstream and the W5300 pins downstream.

Parameters:
SETUP_CYCLES, 1, clk cycles with address/CS valid before strobe (>=1)
STROBE_CYCLES, 7, RD_n/WR_n low width in cycles (70 ns at common::CLK_REF=100 MHz; >=1)
RECOVERY_CYCLES, 3, CS_n high time after a cycle before next accept (>=1)
RST_LOW_CYCLES, 200, hw_rst_n low width (2 us)
RST_WAIT_CYCLES, 1000000, wait after hw_rst_n release before init_done (10 ms PLL lock)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
req_valid  in  1  access request valid
req_ready  out  1  block can accept request
req_op  in  1  W5300::AddrOperation, WR=1 / RD=0
req_addr  in  10  register address, must be even
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read data (0 for writes/errors)
rsp_err  out  1  request rejected (odd address)
init_done  out  1  chip reset sequence complete
hw_rst_n  out  1  W5300 /RESET
bus_addr  out  10  W5300 ADDR[9:0]
bus_data_o  out  16  data to chip
bus_data_i  in  16  data from chip (pad already synchronised outside the block)
bus_data_oe  out  1  data pad output enable
bus_cs_n  out  1  W5300 /CS
bus_rd_n  out  1  W5300 /RD
bus_wr_n  out  1  W5300 /WR

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (all outputs, registered):
  - cs_n=rd_n=wr_n=1
  - hw_rst_n=0, bus_addr=0, bus_data_o=0, bus_data_oe=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0
- FSM states: RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD, ERR, RECOVER. Reset enters RST_LOW.
- RST_LOW:
  - hw_rst_n=0 for RST_LOW_CYCLES, then RST_WAIT.
- RST_WAIT:
  - hw_rst_n=1; after RST_WAIT_CYCLES, init_done=1 (sticky until rst); go to IDLE.
- IDLE:
  - req_ready=1 only in IDLE.
  - Handshake on req_valid & req_ready; the acceptance edge is cycle 0.
  - Address, op and wdata are latched at acceptance; requester inputs are don't-care afterwards.
- Odd req_addr:
  - Go to ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle 1.
  - No bus activity (cs_n stays 1), then IDLE in cycle 2.
- SETUP (cycles 1..S):
  - cs_n=0, bus_addr=latched address.
  - For WR: bus_data_oe=1, bus_data_o=wdata.
- STROBE (cycles S+1..S+P):
  - RD: rd_n=0; bus_data_i registered into rsp_rdata on the last STROBE cycle.
  - WR: wr_n=0, data still driven.
- HOLD (cycle S+P+1):
  - rd_n=wr_n=1; cs_n, address and write data held.
  - rsp_valid=1 for exactly this cycle, rsp_err=0; rsp_rdata valid (0 for WR).
- RECOVER (R cycles):
  - cs_n=1, bus_data_oe=0, req_ready=0, then IDLE.
- Default latency and throughput:
  - rsp_valid at cycle 9 after acceptance.
  - Next acceptance no earlier than cycle 13, i.e. one access per 13 cycles back-to-back.
- rd_n and wr_n are never low simultaneously.
- bus_data_oe is never 1 while rd_n=0.
- rsp_rdata holds its last value until the next response.
- rst asserted in any state, including mid-STROBE:
  - Next cycle all outputs take reset values; any in-flight request is dropped with no response.
  - Chip reset sequence restarts.
- Counters are sized for the maximum parameter via $clog2, and saturate to no wrap.

Test Plan:
- Reset (RST_LOW_CYCLES=4, RST_WAIT_CYCLES=10, rst high 2 cycles) -> hw_rst_n low exactly 4 cycles after rst release, init_done and req_ready rise 10 cycles later, no cs_n activity before.
- Write MR: op=WR, addr=0x000, wdata=0x3800 -> cs_n low 9 cycles, wr_n low cycles 2..8, bus_data_o=0x3800 with oe=1 throughout cs_n low, rsp_valid at cycle 9, rsp_err=0.
- Read IDR: op=RD, addr=0x0FE, chip model drives 0x5300 while rd_n low -> rsp_rdata=0x5300 with rsp_valid at cycle 9, bus_data_oe=0 the whole cycle.
- Back-to-back: req_valid held with writes to 0x200 then 0x202 -> second acceptance exactly 13 cycles after first, cs_n high for 3 cycles between.
- Odd address 0x203 -> rsp_valid+rsp_err at cycle 1, rsp_rdata=0, cs_n never low, ready again cycle 2.
- rst asserted during STROBE of a write -> next cycle wr_n=cs_n=1, oe=0, hw_rst_n=0, no rsp_valid, full reset sequence repeats.

Source files
------------

// File: rtl/w5300_bus_ctrl.sv
// W5300 host bus master (direct address, 16-bit data).
// Runs the chip hardware reset / PLL-lock wait, then turns single register
// requests into CS/RD/WR strobe cycles with fixed setup, strobe, hold and
// recovery timing. All outputs are registered.
module w5300_bus_ctrl #(
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned STROBE_CYCLES   = 7,
  parameter int unsigned RECOVERY_CYCLES = 3,
  parameter int unsigned RST_LOW_CYCLES  = 200,
  parameter int unsigned RST_WAIT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [9:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done,
  output logic        hw_rst_n,
  output logic [9:0]  bus_addr,
  output logic [15:0] bus_data_o,
  input  logic [15:0] bus_data_i,
  output logic        bus_data_oe,
  output logic        bus_cs_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n
);

  localparam int unsigned M0   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned M1   = (M0 > RECOVERY_CYCLES) ? M0 : RECOVERY_CYCLES;
  localparam int unsigned M2   = (M1 > RST_LOW_CYCLES) ? M1 : RST_LOW_CYCLES;
  localparam int unsigned MAXC = (M2 > RST_WAIT_CYCLES) ? M2 : RST_WAIT_CYCLES;
  localparam int          CW   = $clog2(MAXC + 1);

  // Counter values on the final cycle of each timed phase
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST    = CW'(RECOVERY_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LAST    = CW'(RST_LOW_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(RST_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD, ERR, RECOVER
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          op_q;
  logic          ready_q, rsp_valid_q, rsp_err_q, init_done_q, hw_rst_n_q;
  logic          oe_q, cs_n_q, rd_n_q, wr_n_q;
  logic [15:0]   rdata_q, wdata_q;
  logic [9:0]    addr_q;

  // Phase counter saturates instead of wrapping
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Single FSM: reset sequencing plus one bus cycle per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_LOW;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
      hw_rst_n_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        RST_LOW: begin
          if (cnt_q == LOW_LAST) begin
            state_q    <= RST_WAIT;
            hw_rst_n_q <= 1'b1;
            cnt_q      <= '0;
          end else cnt_q <= cnt_inc;
        end
        RST_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            ready_q     <= 1'b1;
            cnt_q       <= '0;
          end else cnt_q <= cnt_inc;
        end
        IDLE: begin
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            cnt_q   <= '0;
            if (req_addr[0]) begin
              // Odd address: reject without touching the bus
              state_q     <= ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rdata_q     <= '0;
            end else begin
              state_q <= SETUP;
              cs_n_q  <= 1'b0;
              addr_q  <= req_addr;
              op_q    <= req_op;
              wdata_q <= req_op ? req_wdata : 16'h0000;
              oe_q    <= req_op;
            end
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= STROBE;
            cnt_q   <= '0;
            rd_n_q  <= op_q;
            wr_n_q  <= ~op_q;
          end else cnt_q <= cnt_inc;
        end
        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            state_q     <= HOLD;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rdata_q     <= op_q ? 16'h0000 : bus_data_i;
          end else cnt_q <= cnt_inc;
        end
        HOLD: begin
          state_q <= RECOVER;
          cs_n_q  <= 1'b1;
          oe_q    <= 1'b0;
          cnt_q   <= '0;
        end
        ERR: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        RECOVER: begin
          if (cnt_q == REC_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else cnt_q <= cnt_inc;
        end
        default: begin
          state_q <= RST_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign init_done   = init_done_q;
  assign hw_rst_n    = hw_rst_n_q;
  assign bus_addr    = addr_q;
  assign bus_data_o  = wdata_q;
  assign bus_data_oe = oe_q;
  assign bus_cs_n    = cs_n_q;
  assign bus_rd_n    = rd_n_q;
  assign bus_wr_n    = wr_n_q;

endmodule
